// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the OV7670 init-ROM sequencer.
package cam_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_SEND   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DELAY  = 3'd5,
        ST_NEXT   = 3'd6,
        ST_DONE   = 3'd7
    } cam_cfg_state_e;

    localparam logic [15:0] CAM_CFG_END    = 16'hFFFF;
    localparam logic [15:0] CAM_CFG_DELAY  = 16'hFFF0;
    localparam logic [7:0]  CAM_SCCB_WR_ID = 8'h42;

    // Counter width able to hold cycles-1; never narrower than one bit.
    function automatic int unsigned cam_cfg_cnt_width(input int unsigned cycles);
        return (cycles > 32'd1) ? $clog2(cycles) : 32'd1;
    endfunction

endpackage

// File: rtl/cam_cfg_delay_timer.sv
// Loadable down-counter for the 0xFFF0 delay marker; o_Zero flags expiry.
module cam_cfg_delay_timer
    import cam_cfg_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 240000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Load,
    input  logic i_En,
    output logic o_Zero
);

    localparam int unsigned CW = cam_cfg_cnt_width(DELAY_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DELAY_CYCLES - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load has priority, then decrement while enabled and non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_Load) begin
            cnt_d = LOAD_VAL;
        end else if (i_En && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Zero = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/camera_config_seq.sv
// Walks the camera init ROM and issues one SCCB write per entry.
// Optional NACK retry is enabled by defining CAM_CFG_RETRY_EN.
module camera_config_seq
    import cam_cfg_pkg::*;
#(
    parameter logic [7:0]  DEV_ID       = CAM_SCCB_WR_ID,
    parameter int unsigned DELAY_CYCLES = 240000
`ifdef CAM_CFG_RETRY_EN
    ,
    parameter int unsigned RETRY_MAX    = 3
`endif
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    output logic [7:0]  o_Rom_Addr,
    input  logic [15:0] i_Rom_Data,
    output logic        o_Sccb_Req,
    input  logic        i_Sccb_Ack,
    output logic [7:0]  o_Sccb_Id,
    output logic [7:0]  o_Sccb_Reg,
    output logic [7:0]  o_Sccb_Val,
    input  logic        i_Sccb_Done,
    input  logic        i_Sccb_Nack,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Err
);

    cam_cfg_state_e state_q;
    logic [7:0]     idx_q;
    logic [7:0]     rom_addr_q;
    logic           req_q;
    logic [7:0]     id_q;
    logic [7:0]     reg_q;
    logic [7:0]     val_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
`ifdef CAM_CFG_RETRY_EN
    logic [7:0]     retry_q;
`endif

    logic tmr_load_s;
    logic tmr_en_s;
    logic tmr_zero_s;

    // Timer is loaded while decoding a delay marker and runs only in DELAY.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_en_s   = 1'b0;
        if (state_q == ST_DECODE) begin
            tmr_load_s = (i_Rom_Data == CAM_CFG_DELAY);
        end else if (state_q == ST_DELAY) begin
            tmr_en_s = 1'b1;
        end else begin
            tmr_load_s = 1'b0;
            tmr_en_s   = 1'b0;
        end
    end

    cam_cfg_delay_timer #(
        .DELAY_CYCLES (DELAY_CYCLES)
    ) u_delay_timer (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Load (tmr_load_s),
        .i_En   (tmr_en_s),
        .o_Zero (tmr_zero_s)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 8'd0;
            rom_addr_q <= 8'd0;
            req_q      <= 1'b0;
            id_q       <= 8'd0;
            reg_q      <= 8'd0;
            val_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef CAM_CFG_RETRY_EN
            retry_q    <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Start) begin
                        idx_q      <= 8'd0;
                        rom_addr_q <= 8'd0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (i_Rom_Data == CAM_CFG_END) begin
                        state_q <= ST_DONE;
                    end else if (i_Rom_Data == CAM_CFG_DELAY) begin
                        state_q <= ST_DELAY;
                    end else begin
                        id_q    <= DEV_ID;
                        reg_q   <= i_Rom_Data[15:8];
                        val_q   <= i_Rom_Data[7:0];
                        req_q   <= 1'b1;
`ifdef CAM_CFG_RETRY_EN
                        retry_q <= 8'd0;
`endif
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (req_q && i_Sccb_Ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_Sccb_Done) begin
                        if (!i_Sccb_Nack) begin
                            state_q <= ST_NEXT;
                        end else begin
`ifdef CAM_CFG_RETRY_EN
                            if (retry_q == 8'(RETRY_MAX)) begin
                                err_q   <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                retry_q <= retry_q + 8'd1;
                                req_q   <= 1'b1;
                                state_q <= ST_SEND;
                            end
`else
                            err_q   <= 1'b1;
                            state_q <= ST_NEXT;
`endif
                        end
                    end
                end
                ST_DELAY: begin
                    if (tmr_zero_s) begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // Index 0xFF without an end marker is a malformed table.
                    if (idx_q == 8'hFF) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q      <= idx_q + 8'd1;
                        rom_addr_q <= idx_q + 8'd1;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Rom_Addr = rom_addr_q;
    assign o_Sccb_Req = req_q;
    assign o_Sccb_Id  = id_q;
    assign o_Sccb_Reg = reg_q;
    assign o_Sccb_Val = val_q;
    assign o_Busy     = busy_q;
    assign o_Done     = done_q;
    assign o_Err      = err_q;

endmodule

// File: tb/tb_camera_config_seq.sv
// Directed bench for camera_config_seq: ROM and SCCB master models plus vector table.
module tb_camera_config_seq;

    localparam int unsigned DLY = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_q;
    logic        req;
    logic        ack;
    logic [7:0]  id_o;
    logic [7:0]  reg_o;
    logic [7:0]  val_o;
    logic        sdone;
    logic        snack;
    logic        busy;
    logic        done;
    logic        err;

    camera_config_seq #(
        .DEV_ID       (8'h42),
        .DELAY_CYCLES (DLY)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Start     (start),
        .o_Rom_Addr  (rom_addr),
        .i_Rom_Data  (rom_q),
        .o_Sccb_Req  (req),
        .i_Sccb_Ack  (ack),
        .o_Sccb_Id   (id_o),
        .o_Sccb_Reg  (reg_o),
        .o_Sccb_Val  (val_o),
        .i_Sccb_Done (sdone),
        .i_Sccb_Nack (snack),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Err       (err)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_mem [256];
    int          cyc = 0;

    always @(posedge clk) begin
        rom_q <= rom_mem[rom_addr];
        cyc   <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SCCB master model state
    int          ack_wait = 0;
    int          done_lat = 20;
    logic [8:0]  nack_reg = 9'd0;
    logic [23:0] log_q [$];
    int          done_cyc_q [$];
    int          seen = 0;
    int          dcnt = 0;
    bit          pend = 0;
    bit          stable = 1;
    logic [15:0] first_rv;
    logic [7:0]  acc_reg;
    bit          addr2_seen = 0;
    int          addr2_cyc = 0;
    int          req_in_delay = 0;

    initial begin
        ack = 1'b0; sdone = 1'b0; snack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ack = 1'b0; sdone = 1'b0; snack = 1'b0;
                pend = 0; seen = 0; stable = 1;
            end else begin
                sdone = 1'b0; snack = 1'b0;
                if (pend) begin
                    if (dcnt <= 1) begin
                        sdone = 1'b1;
                        snack = nack_reg[8] && (acc_reg == nack_reg[7:0]);
                        pend  = 0;
                        done_cyc_q.push_back(cyc + 1);
                    end else begin
                        dcnt--;
                    end
                end
                if (ack) begin
                    ack = 1'b0;
                end else if (req) begin
                    if (seen == 0) begin
                        first_rv = {reg_o, val_o};
                        stable   = 1;
                    end else if ({reg_o, val_o} !== first_rv) begin
                        stable = 0;
                    end
                    seen++;
                    if (seen > ack_wait) begin
                        ack = 1'b1;
                        chk("req_stable", {31'd0, stable}, 32'd1);
                        log_q.push_back({id_o, reg_o, val_o});
                        acc_reg = reg_o;
                        pend = 1;
                        dcnt = done_lat;
                        seen = 0;
                    end
                end else if (seen > 0) begin
                    total++; bad++;
                    $display("FAIL req_dropped: got 0 expected 1");
                    seen = 0;
                end
                if (rom_addr == 8'd2 && !addr2_seen) begin
                    addr2_seen = 1;
                    addr2_cyc  = cyc;
                end
                if (req && rom_addr == 8'd1) req_in_delay++;
            end
        end
    end

    typedef struct {
        logic [3:0][15:0] e;
        int               ack_wait;
        logic [8:0]       nack_reg;
        int               n;
        logic [5:0][15:0] w;
        logic             err;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] e0, e1, e2, e3, input int aw,
                                input logic [8:0] nr, input int n,
                                input logic [15:0] w0, w1, w2, w3, w4, input logic er);
        vec_t v;
        v.e = {e3, e2, e1, e0};
        v.ack_wait = aw;
        v.nack_reg = nr;
        v.n = n;
        v.w = {16'h0000, w4, w3, w2, w1, w0};
        v.err = er;
        return v;
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!(done && !busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            total++; bad++;
            $display("FAIL %s_timeout: got busy=%0b done=%0b expected done", name, busy, done);
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        done_cyc_q.delete();
        addr2_seen = 0;
        req_in_delay = 0;
    endtask

    task automatic load_rom(input logic [3:0][15:0] e);
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        for (int i = 0; i < 4; i++) rom_mem[i] = e[i];
    endtask

    vec_t vecs [5];

    initial begin
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;

        vecs[0] = mk(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 0, 9'd0, 2,
                     16'h1280, 16'h1100, 16'h0, 16'h0, 16'h0, 1'b0);
        vecs[1] = mk(16'hFF12, 16'h3456, 16'hFFFF, 16'h0000, 0, 9'd0, 2,
                     16'hFF12, 16'h3456, 16'h0, 16'h0, 16'h0, 1'b0);
`ifdef CAM_CFG_RETRY_EN
        vecs[2] = mk(16'h1280, 16'h1100, 16'h1300, 16'hFFFF, 7, 9'h111, 5,
                     16'h1280, 16'h1100, 16'h1100, 16'h1100, 16'h1100, 1'b1);
`else
        vecs[2] = mk(16'h1280, 16'h1100, 16'h1300, 16'hFFFF, 7, 9'h111, 3,
                     16'h1280, 16'h1100, 16'h1300, 16'h0, 16'h0, 1'b1);
`endif
        vecs[3] = mk(16'hFFFF, 16'h1280, 16'h1100, 16'hFFFF, 0, 9'd0, 0,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        vecs[4] = mk(16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF, 0, 9'd0, 2,
                     16'h1280, 16'h1204, 16'h0, 16'h0, 16'h0, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err",  {31'd0, err},  32'd0);
        chk("rst_req",  {31'd0, req},  32'd0);
        chk("rst_addr", {24'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            load_rom(vecs[v].e);
            ack_wait = vecs[v].ack_wait;
            nack_reg = vecs[v].nack_reg;
            done_lat = 20;
            clear_logs();
            pulse_start();
            chk("start_busy", {31'd0, busy}, 32'd1);
            wait_done("vec", 2000);
            chk("vec_nwrites", log_q.size(), vecs[v].n);
            for (int i = 0; i < vecs[v].n && i < log_q.size(); i++) begin
                chk("vec_write", {16'd0, log_q[i][15:0]}, {16'd0, vecs[v].w[i]});
                chk("vec_id", {24'd0, log_q[i][23:16]}, 32'h42);
            end
            chk("vec_err",  {31'd0, err},  {31'd0, vecs[v].err});
            chk("vec_done", {31'd0, done}, 32'd1);
            chk("vec_busy", {31'd0, busy}, 32'd0);
            if (v == 4) begin
                chk("delay_span", addr2_cyc - ((done_cyc_q.size() > 0) ? done_cyc_q[0] : 0), DLY + 4);
                chk("delay_noreq", req_in_delay, 0);
            end
        end

        // i_Start while busy is ignored
        load_rom({16'h0000, 16'hFFFF, 16'h1100, 16'h1280});
        ack_wait = 0; nack_reg = 9'd0; done_lat = 20;
        clear_logs();
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_done("midstart", 2000);
        chk("midstart_n", log_q.size(), 2);
        if (log_q.size() >= 2) chk("midstart_w1", {16'd0, log_q[1][15:0]}, 32'h1100);

        // Reset during SEND aborts immediately, then restart from index 0
        load_rom({16'h0000, 16'h0000, 16'hFFFF, 16'h1280});
        ack_wait = 100;
        clear_logs();
        pulse_start();
        for (int k = 0; k < 50 && !req; k++) @(negedge clk);
        chk("send_req", {31'd0, req}, 32'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_req",  {31'd0, req},  32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        ack_wait = 0;
        clear_logs();
        pulse_start();
        chk("restart_addr", {24'd0, rom_addr}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_done("restart", 2000);
        chk("restart_n", log_q.size(), 1);
        if (log_q.size() >= 1) chk("restart_w0", {16'd0, log_q[0][15:0]}, 32'h1280);
        chk("restart_err", {31'd0, err}, 32'd0);

        // Table without end marker: 256 writes, then overflow error
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'h1234;
        ack_wait = 0; done_lat = 1;
        clear_logs();
        pulse_start();
        wait_done("ovf", 6000);
        chk("ovf_n",    log_q.size(), 256);
        chk("ovf_err",  {31'd0, err},  32'd1);
        chk("ovf_done", {31'd0, done}, 32'd1);
        chk("ovf_addr", {24'd0, rom_addr}, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
